// File: rtl/adder_sub_pkg.sv
// Shared types, default widths and the extended-width add/sub helper for adder_sub_pipe.
package adder_sub_pkg;

  localparam int DATA_WIDTH_DEF = 4;
  localparam int ACC_WIDTH_DEF  = 8;
  localparam int ACC_MAX_W      = 32;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_ACC_ADD, OP_ACC_SUB} op_mode_e;

  typedef struct packed {
    logic                 ovf;
    logic [ACC_MAX_W-1:0] res;
  } addsub_t;

  // Unsigned base +/- opnd, both assumed to fit in `width` bits; ovf marks a true
  // result at or above 2^width (add) or below zero (sub).
  function automatic addsub_t addsub_ext(input logic [ACC_MAX_W-1:0] base,
                                         input logic [ACC_MAX_W-1:0] opnd,
                                         input logic                 sub,
                                         input int unsigned          width);
    logic [ACC_MAX_W:0] full;
    addsub_t            r;
    if (sub) full = {1'b0, base} - {1'b0, opnd};
    else     full = {1'b0, base} + {1'b0, opnd};
    r.ovf = sub ? (opnd > base) : ((full >> width) != '0);
    r.res = full[ACC_MAX_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/adder_sub_pipe_stage.sv
// Generic valid/ready register slice; payload is loaded on an input transfer.
module adder_sub_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) out_valid <= 1'b0;
    else if (in_ready) out_valid <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) out_data <= in_data;
  end

endmodule

// File: rtl/adder_sub_pipe.sv
// Two-stage pipelined add/sub with accumulate modes and valid/ready on both sides.
// Define ADDER_SUB_SAT_EN to clamp accumulate results instead of wrapping.
module adder_sub_pipe
  import adder_sub_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  input  logic [DATA_WIDTH-1:0] data_in_2,
  input  logic [1:0]            mode,
  input  logic                  acc_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH:0]   data_out,
  output logic [ACC_WIDTH-1:0]  acc_out,
  output logic                  ovf
);

  localparam int S1_W = 2 * DATA_WIDTH + 3;

  logic                  adv;
  logic                  s1_valid;
  logic [S1_W-1:0]       s1_data;
  logic [DATA_WIDTH-1:0] s1_a, s1_b;
  logic [1:0]            s1_mode_raw;
  logic                  s1_clr;
  op_mode_e              s1_mode;

  logic                  is_acc, is_sub;
  logic [ACC_WIDTH-1:0]  base;
  logic [ACC_MAX_W-1:0]  op_x, op_y;
  int unsigned           op_w;
  addsub_t               r;
  logic [DATA_WIDTH:0]   nxt_data;
  logic [ACC_WIDTH-1:0]  nxt_acc;
  logic                  nxt_ovf;

  assign adv = !out_valid || out_ready;

  adder_sub_pipe_stage #(.WIDTH(S1_W)) u_stage1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  ({data_in_1, data_in_2, mode, acc_clr}),
    .out_valid(s1_valid),
    .out_ready(adv),
    .out_data (s1_data)
  );

  assign {s1_a, s1_b, s1_mode_raw, s1_clr} = s1_data;
  assign s1_mode = op_mode_e'(s1_mode_raw);

  // Plain add/sub run at DATA_WIDTH+1 so the carry/borrow lands in the MSB.
  always_comb begin
    is_acc   = (s1_mode == OP_ACC_ADD) || (s1_mode == OP_ACC_SUB);
    is_sub   = (s1_mode == OP_SUB) || (s1_mode == OP_ACC_SUB);
    base     = s1_clr ? '0 : acc_out;
    op_x     = is_acc ? ACC_MAX_W'(base) : ACC_MAX_W'(s1_a);
    op_y     = is_acc ? ACC_MAX_W'(s1_a) : ACC_MAX_W'(s1_b);
    op_w     = is_acc ? ACC_WIDTH : DATA_WIDTH + 1;
    r        = addsub_ext(op_x, op_y, is_sub, op_w);
    nxt_acc  = base;
    nxt_ovf  = 1'b0;
    nxt_data = r.res[DATA_WIDTH:0];
    if (is_acc) begin
      nxt_ovf = r.ovf;
`ifdef ADDER_SUB_SAT_EN
      if (r.ovf) nxt_acc = is_sub ? '0 : '1;
      else       nxt_acc = r.res[ACC_WIDTH-1:0];
`else
      nxt_acc = r.res[ACC_WIDTH-1:0];
`endif
      nxt_data = nxt_acc[DATA_WIDTH:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      acc_out   <= '0;
      ovf       <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        data_out <= nxt_data;
        acc_out  <= nxt_acc;
        ovf      <= nxt_ovf;
      end
    end
  end

endmodule

// File: tb/tb_adder_sub_pipe.sv
// Scoreboard bench for adder_sub_pipe (DATA_WIDTH=4, ACC_WIDTH=8); honours ADDER_SUB_SAT_EN.
module tb_adder_sub_pipe;

  localparam int DW = 4;
  localparam int AW = 8;

  typedef struct {
    logic [DW:0]   d;
    logic [AW-1:0] acc;
    logic          ovf;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] data_in_1 = '0;
  logic [DW-1:0] data_in_2 = '0;
  logic [1:0]    mode = 2'b00;
  logic          acc_clr = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW:0]   data_out;
  logic [AW-1:0] acc_out;
  logic          ovf;

  logic          ready_force = 1'b1;
  logic          rand_ready = 1'b0;

  int            n_checks = 0;
  int            n_errors = 0;
  exp_t          sb[$];
  int            m_acc = 0;
  logic [DW:0]   last_d;
  logic [AW-1:0] last_acc;
  logic          last_ovf;

  adder_sub_pipe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_in_1(data_in_1),
    .data_in_2(data_in_2),
    .mode     (mode),
    .acc_clr  (acc_clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out),
    .acc_out  (acc_out),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [1:0] md, input int a, input int b, input logic clr);
    exp_t e;
    int   t;
    e.ovf = 1'b0;
    if (md == 2'd0 || md == 2'd1) begin
      t = (md == 2'd0) ? a + b : a - b;
      e.d = 5'((t + 32) % 32);
      if (clr) m_acc = 0;
    end else begin
      t = (clr ? 0 : m_acc) + ((md == 2'd2) ? a : -a);
      e.ovf = (t > 255) || (t < 0);
`ifdef ADDER_SUB_SAT_EN
      m_acc = (t > 255) ? 255 : (t < 0) ? 0 : t;
`else
      m_acc = (t + 256) % 256;
`endif
      e.d = 5'(m_acc % 32);
    end
    e.acc = 8'(m_acc);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      m_acc = 0;
    end else begin
      if (in_valid && in_ready)
        sb.push_back(model(mode, int'(data_in_1), int'(data_in_2), acc_clr));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("data_out", 32'(data_out), 32'(e.d));
          chk("acc_out", 32'(acc_out), 32'(e.acc));
          chk("ovf", 32'(ovf), 32'(e.ovf));
        end
        last_d   = data_out;
        last_acc = acc_out;
        last_ovf = ovf;
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that took the beat.
  task automatic send(input logic [1:0] md, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic clr);
    logic got;
    got = 1'b0;
    mode = md; data_in_1 = a; data_in_2 = b; acc_clr = clr; in_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!got) chk("in_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 500 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    cycles(2);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_acc_out", 32'(acc_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    cycles(1);

    // Latency: beat taken at e1, result visible after e2.
    send(2'd0, 4'hF, 4'h1, 1'b0);
    chk("lat_not_1", 32'(out_valid), 32'd0);
    cycles(1);
    chk("lat_2_valid", 32'(out_valid), 32'd1);
    chk("add_F_1", 32'(data_out), 32'h10);
    send(2'd1, 4'h3, 4'h5, 1'b0);
    drain();
    chk("sub_3_5", 32'(last_d), 32'h1E);

    send(2'd2, 4'hF, 4'h0, 1'b1);
    for (int i = 0; i < 17; i++) send(2'd2, 4'hF, 4'h0, 1'b0);
    drain();
`ifdef ADDER_SUB_SAT_EN
    chk("acc18_val", 32'(last_acc), 32'hFF);
`else
    chk("acc18_val", 32'(last_acc), 32'h0E);
`endif
    chk("acc18_ovf", 32'(last_ovf), 32'd1);

    send(2'd3, 4'h1, 4'h0, 1'b1);
    drain();
`ifdef ADDER_SUB_SAT_EN
    chk("accsub_val", 32'(last_acc), 32'h00);
    chk("accsub_d", 32'(last_d), 32'h00);
`else
    chk("accsub_val", 32'(last_acc), 32'hFF);
    chk("accsub_d", 32'(last_d), 32'h1F);
`endif
    chk("accsub_ovf", 32'(last_ovf), 32'd1);

    // Backpressure: two beats fill the pipe, the third must wait.
    ready_force = 1'b0;
    cycles(1);
    send(2'd0, 4'h2, 4'h3, 1'b0);
    send(2'd0, 4'h4, 4'h4, 1'b0);
    mode = 2'd1; data_in_1 = 4'h1; data_in_2 = 4'h2; acc_clr = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data", 32'(data_out), 32'h05);
      @(posedge clk); #1;
    end
    ready_force = 1'b1;
    send(2'd1, 4'h1, 4'h2, 1'b0);
    send(2'd0, 4'h9, 4'h9, 1'b0);
    drain();
    chk("bp_acc_unchanged", 32'(acc_out), 32'(m_acc));

    // Reset with both stages occupied.
    send(2'd2, 4'h7, 4'h0, 1'b1);
    drain();
    ready_force = 1'b0;
    cycles(1);
    send(2'd0, 4'h1, 4'h1, 1'b0);
    send(2'd0, 4'h2, 4'h2, 1'b0);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_acc", 32'(acc_out), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    ready_force = 1'b1;
    cycles(6);
    chk("mid_rst_no_stale", 32'(out_valid), 32'd0);

    rand_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      cycles($urandom_range(0, 2));
      send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           $urandom_range(0, 7) == 0);
    end
    drain();
    rand_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
